// File: rtl/dmi_host_seq.sv
`timescale 1ns/1ps
// dmi_host_seq: host-side DMI initiator.
// Turns single host register read/write requests into DMI request/response
// transactions. BUSY responses are retried after a backoff, and the wait for
// a response is bounded by a timeout.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | ready for a host request
// ISSUE    | DMI request presented, waiting for dmi_req_ready_i
// WAIT_RSP | request accepted, waiting for a DMI response (timeout running)
// BACKOFF  | BUSY seen, idling before re-issuing the same request
// RESP     | host response held until host_rsp_ready_i
module dmi_host_seq #(
    parameter int AddrWidth     = 7,
    parameter int MaxRetries    = 8,
    parameter int RetryBackoff  = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 host_req_valid_i,
    output logic                 host_req_ready_o,
    input  logic [AddrWidth-1:0] host_addr_i,
    input  logic                 host_we_i,
    input  logic [31:0]          host_wdata_i,
    output logic                 host_rsp_valid_o,
    input  logic                 host_rsp_ready_i,
    output logic [31:0]          host_rdata_o,
    output logic [1:0]           host_status_o,
    output logic                 dmi_req_valid_o,
    input  logic                 dmi_req_ready_i,
    output logic [31:0]          dmi_req_addr_o,
    output logic [1:0]           dmi_req_op_o,
    output logic [31:0]          dmi_req_data_o,
    input  logic                 dmi_resp_valid_i,
    output logic                 dmi_resp_ready_o,
    input  logic [31:0]          dmi_resp_data_i,
    input  logic [1:0]           dmi_resp_resp_i,
    output logic                 busy_o,
    output logic                 stale_o
);

    localparam int RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
    localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam int BW = (RetryBackoff > 1) ? $clog2(RetryBackoff) : 1;

    localparam logic [RW-1:0] RETRY_MAX    = RW'(MaxRetries);
    localparam logic [TW-1:0] TMO_LAST     = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [TW-1:0] TMO_SAT      = '1;
    localparam logic [BW-1:0] BACKOFF_LOAD = BW'((RetryBackoff > 0) ? RetryBackoff - 1 : 0);

    localparam logic [1:0] OP_READ  = 2'd1;
    localparam logic [1:0] OP_WRITE = 2'd2;

    localparam logic [1:0] RESP_SUCCESS = 2'd0;
    localparam logic [1:0] RESP_BUSY    = 2'd3;

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_TIMEOUT  = 2'd1;
    localparam logic [1:0] ST_ERROR    = 2'd2;
    localparam logic [1:0] ST_BUSY_EXH = 2'd3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_RSP = 3'd2,
        BACKOFF  = 3'd3,
        RESP     = 3'd4
    } state_t;

    state_t state_q, state_d;

    // Goes high one cycle after reset release; gates everything that must
    // read 0 while in reset.
    logic                 out_en_q;

    logic [AddrWidth-1:0] addr_q;
    logic                 we_q;
    logic [31:0]          wdata_q;

    logic [RW-1:0]        retry_q;
    logic [TW-1:0]        tmo_q;
    logic [BW-1:0]        backoff_q;

    logic [31:0]          rsp_data_q, rsp_data_d;
    logic [1:0]           rsp_status_q, rsp_status_d;
    logic                 rsp_load;
    logic                 retry_inc;

    logic                 req_hs;
    logic                 dmi_req_hs;
    logic                 resp_hs;
    logic                 tmo_hit;
    logic                 issuing;

    assign issuing    = (state_q == ISSUE);
    assign req_hs     = host_req_valid_i && host_req_ready_o;
    assign dmi_req_hs = issuing && dmi_req_ready_i;
    assign resp_hs    = dmi_resp_valid_i && dmi_resp_ready_o;
    assign tmo_hit    = (TimeoutCycles != 0) && (tmo_q == TMO_LAST);

    assign host_req_ready_o = out_en_q && (state_q == IDLE);
    assign host_rsp_valid_o = (state_q == RESP);
    assign host_rdata_o     = rsp_data_q;
    assign host_status_o    = rsp_status_q;

    // Request fields come only from the captured registers, so they stay
    // stable for as long as ISSUE waits for dmi_req_ready_i.
    assign dmi_req_valid_o  = issuing;
    assign dmi_req_addr_o   = issuing ? 32'(addr_q) : 32'd0;
    assign dmi_req_op_o     = issuing ? (we_q ? OP_WRITE : OP_READ) : 2'd0;
    assign dmi_req_data_o   = (issuing && we_q) ? wdata_q : 32'd0;
    assign dmi_resp_ready_o = out_en_q;

    assign busy_o  = (state_q != IDLE);
    assign stale_o = resp_hs && (state_q != WAIT_RSP);

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and response classification.
    always_comb begin
        state_d      = state_q;
        rsp_load     = 1'b0;
        rsp_status_d = ST_OK;
        rsp_data_d   = 32'd0;
        retry_inc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_hs) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (dmi_req_ready_i) begin
                    state_d = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                // A response in the same cycle as timeout expiry wins.
                if (resp_hs) begin
                    if (dmi_resp_resp_i == RESP_SUCCESS) begin
                        rsp_load     = 1'b1;
                        rsp_status_d = ST_OK;
                        rsp_data_d   = we_q ? 32'd0 : dmi_resp_data_i;
                        state_d      = RESP;
                    end else if ((dmi_resp_resp_i == RESP_BUSY) && (retry_q < RETRY_MAX)) begin
                        retry_inc = 1'b1;
                        state_d   = BACKOFF;
                    end else if (dmi_resp_resp_i == RESP_BUSY) begin
                        rsp_load     = 1'b1;
                        rsp_status_d = ST_BUSY_EXH;
                        state_d      = RESP;
                    end else begin
                        // ERR and the reserved code are both reported as error.
                        rsp_load     = 1'b1;
                        rsp_status_d = ST_ERROR;
                        state_d      = RESP;
                    end
                end else if (tmo_hit) begin
                    rsp_load     = 1'b1;
                    rsp_status_d = ST_TIMEOUT;
                    state_d      = RESP;
                end
            end
            BACKOFF: begin
                if (backoff_q == '0) begin
                    state_d = ISSUE;
                end
            end
            RESP: begin
                if (host_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output enable: asserted from the first clock after reset release.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
        end
    end

    // Capture the host request on acceptance.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= 32'd0;
        end else if (req_hs) begin
            addr_q  <= host_addr_i;
            we_q    <= host_we_i;
            wdata_q <= host_wdata_i;
        end
    end

    // Retry counter: cleared per transaction, bumped on each retried BUSY.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_q <= '0;
        end else if (req_hs) begin
            retry_q <= '0;
        end else if (retry_inc) begin
            retry_q <= retry_q + RW'(1);
        end
    end

    // Timeout counter: runs only in WAIT_RSP and saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_q <= '0;
        end else if (req_hs || dmi_req_hs) begin
            tmo_q <= '0;
        end else if ((state_q == WAIT_RSP) && (tmo_q != TMO_SAT)) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Backoff down-counter: loaded on a retried BUSY, ISSUE follows at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            backoff_q <= '0;
        end else if (retry_inc) begin
            backoff_q <= BACKOFF_LOAD;
        end else if ((state_q == BACKOFF) && (backoff_q != '0)) begin
            backoff_q <= backoff_q - BW'(1);
        end
    end

    // Host response registers: loaded on completion, cleared once taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_data_q   <= 32'd0;
            rsp_status_q <= ST_OK;
        end else if (rsp_load) begin
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end else if ((state_q == RESP) && host_rsp_ready_i) begin
            rsp_data_q   <= 32'd0;
            rsp_status_q <= ST_OK;
        end
    end

endmodule

// File: doc/dmi_host_seq.md
Name: dmi_host_seq

Overview:
- Host-side DMI initiator: converts single register read/write requests from a debug host into DMI request/response transactions (op/addr/data, resp codes SUCCESS=0, ERR=2, BUSY=3) toward the debug module's DMI port.
- Retries on BUSY with backoff and enforces a response timeout.
- Sits between a JTAG DTM/bridge front end and the debug module.

Parameters:
- AddrWidth, 7, DMI address bits (abits); zero-extended to 32 on the DMI side.
- MaxRetries, 8, BUSY responses retried before giving up.
- RetryBackoff, 4, idle cycles between a BUSY response and the re-issue (>=1).
- TimeoutCycles, 1024, max cycles in WAIT_RSP; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- host_req_valid_i  in  1  host request valid
- host_req_ready_o  out  1  request accepted when valid&ready
- host_addr_i  in  AddrWidth  DMI register address
- host_we_i  in  1  1=write, 0=read
- host_wdata_i  in  32  write data
- host_rsp_valid_o  out  1  response valid
- host_rsp_ready_i  in  1  host takes response
- host_rdata_o  out  32  read data (0 for writes and failures)
- host_status_o  out  2  0=ok, 1=timeout, 2=error, 3=busy exhausted
- dmi_req_valid_o  out  1  DMI request valid
- dmi_req_ready_i  in  1  DMI request accepted
- dmi_req_addr_o  out  32  {zeros, addr}
- dmi_req_op_o  out  2  1=READ, 2=WRITE
- dmi_req_data_o  out  32  wdata for writes, 0 for reads
- dmi_resp_valid_i  in  1  DMI response valid
- dmi_resp_ready_o  out  1  constant 1 out of reset
- dmi_resp_data_i  in  32  response data
- dmi_resp_resp_i  in  2  response code
- busy_o  out  1  state != IDLE
- stale_o  out  1  one-cycle pulse when a response arrives outside WAIT_RSP

Behaviour:
Reset values:
- All outputs 0, except dmi_resp_ready_o = 1 after reset release.
- State IDLE; all counters 0.
- Reset asserted mid-transaction abandons it with no host response.

FSM states: IDLE, ISSUE, WAIT_RSP, BACKOFF, RESP.
- IDLE:
  - host_req_ready_o = 1.
  - On a handshake: capture addr/we/wdata, clear the retry and timeout counters, go to ISSUE.
- ISSUE:
  - dmi_req_valid_o = 1.
  - addr/op/data driven from captured regs and stable until dmi_req_ready_i.
  - On a handshake: clear the timeout counter, go to WAIT_RSP.
  - Timeout does not run in ISSUE.
- WAIT_RSP: timeout counter increments each cycle. On a response (priority top-down):
  - code 0: RESP, status 0; rdata = dmi_resp_data_i for reads, 0 for writes.
  - code 3 with retry count < MaxRetries: increment retry count, go to BACKOFF.
  - code 3 with retry count = MaxRetries: RESP, status 3.
  - code 2 or reserved 1: RESP, status 2.
  - No response and counter reaches TimeoutCycles-1: RESP, status 1.
  - Response in the same cycle as expiry: the response wins.
- BACKOFF:
  - Counts RetryBackoff cycles, then returns to ISSUE with identical fields.
- RESP:
  - host_rsp_valid_o held with data/status stable until host_rsp_ready_i, then IDLE.

Timing and counts:
- Minimum latency: host accept at cycle N, dmi_req_valid_o at N+1.
- Response accepted at M gives host_rsp_valid_o at M+1.
- At least one IDLE cycle between transactions; no pipelining; one outstanding request.
- Total DMI issues per transaction <= MaxRetries+1.
- Retry counter width: clog2(MaxRetries+1). Timeout counter saturates.

Stale responses:
- A response arriving in any state other than WAIT_RSP (e.g. late after a timeout) is consumed and discarded.
- It pulses stale_o and does not change state.

Test Plan:
- Read 0x11; response SUCCESS, data 0x00400382, 3 cycles after the request handshake -> dmi_req op=1, addr=0x00000011, data=0 one cycle after accept; host sees status 0, rdata 0x00400382.
- Write 0x17, data 0x00231000, dmi_req_ready_i low 5 cycles -> valid/addr/op=2/data stable all 5 cycles; one request issued; SUCCESS -> status 0, rdata 0.
- BUSY, BUSY, then SUCCESS (data 0xCAFE0001) -> exactly 3 issues, each re-issue >= 4 cycles after the BUSY; status 0, rdata 0xCAFE0001.
- MaxRetries=8, always BUSY -> exactly 9 issues, then status 3, rdata 0; ERR response on a fresh read -> status 2.
- No response -> status 1 exactly 1024 cycles after the handshake; a late response 10 cycles later -> stale_o pulse, no host response, next transaction normal.
- rst_i asserted in WAIT_RSP with host_rsp_ready_i low -> all outputs at reset values immediately; after release, a read of 0x04 completes normally.
